// File: rtl/ct_f_spsram_512x7_ctrl_if.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_512x7_ctrl_if
//
// Bundles the two requester ports and the SRAM pin bus of the 512x7
// single-port SRAM controller.
//
//   Requester n (n = 0,1):
//     rn_req    client -> ctrl  access request, held until granted
//     rn_wr     client -> ctrl  1 = write, 0 = read
//     rn_addr   client -> ctrl  access address
//     rn_wdata  client -> ctrl  write data
//     rn_wmask  client -> ctrl  per-bit write enable, active-high
//     rn_gnt    ctrl -> client  combinational grant (transfer = req & gnt)
//     rn_rvalid ctrl -> client  read data valid, one cycle after read grant
//     rn_rdata  ctrl -> client  read data (meaningful only while rvalid)
//   SRAM pins:
//     A, CEN, GWEN, WEN, D      ctrl -> SRAM (CEN/GWEN/WEN active-low)
//     Q                         SRAM -> ctrl, valid the cycle after a read
//
// Modports: slave = controller side, master = client/SRAM side.
// ---------------------------------------------------------------------------
interface ct_f_spsram_512x7_ctrl_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 7
);
    logic                  r0_req;
    logic                  r0_wr;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic [DATA_WIDTH-1:0] r0_wmask;
    logic                  r0_gnt;
    logic                  r0_rvalid;
    logic [DATA_WIDTH-1:0] r0_rdata;

    logic                  r1_req;
    logic                  r1_wr;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic [DATA_WIDTH-1:0] r1_wmask;
    logic                  r1_gnt;
    logic                  r1_rvalid;
    logic [DATA_WIDTH-1:0] r1_rdata;

    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [DATA_WIDTH-1:0] WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;

    modport slave (
        input  r0_req, r0_wr, r0_addr, r0_wdata, r0_wmask,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_wr, r1_addr, r1_wdata, r1_wmask,
        output r1_gnt, r1_rvalid, r1_rdata,
        output A, CEN, GWEN, WEN, D,
        input  Q
    );

    modport master (
        output r0_req, r0_wr, r0_addr, r0_wdata, r0_wmask,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_wr, r1_addr, r1_wdata, r1_wmask,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  A, CEN, GWEN, WEN, D,
        output Q
    );
endinterface

// File: rtl/ct_f_spsram_512x7_ctrl.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_512x7_ctrl
//
// Controller and two-port round-robin arbiter for a 512x7 single-port SRAM.
// After reset (or a clr_req pulse while arbitrating) the whole array is swept
// and written with INIT_VAL, one entry per cycle. Afterwards the single SRAM
// port is shared between two requesters: one access per cycle, combinational
// grant, per-bit write masks, read data returned one cycle after the grant.
//
// Ports:
//   CLK        in   clock, all logic on posedge
//   RST        in   synchronous reset, active-high
//   clr_req    in   pulse: re-run init sweep (honoured only while arbitrating)
//   init_busy  out  high while the init sweep is in progress
//   bus        slave modport of ct_f_spsram_512x7_ctrl_if (requesters + SRAM)
// ---------------------------------------------------------------------------
module ct_f_spsram_512x7_ctrl #(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 7,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clr_req,
    output logic                     init_busy,
    ct_f_spsram_512x7_ctrl_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    // Index of the requester granted last; the other one wins a tie.
    logic                  rr_q, rr_d;
    logic [1:0]            rvalid_q, rvalid_d;

    // Arbitration result for this cycle.
    logic                  acc;
    logic                  sel;

    // Fields of the selected requester.
    logic                  s_wr;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [DATA_WIDTH-1:0] s_wmask;

    // -----------------------------------------------------------------------
    // Arbitration: who would win the port this cycle (only acted on in ARB)
    // -----------------------------------------------------------------------
    always_comb begin
        acc = 1'b0;
        sel = 1'b0;
        if (bus.r0_req && bus.r1_req) begin
            acc = 1'b1;
            sel = ~rr_q;
        end else if (bus.r0_req) begin
            acc = 1'b1;
            sel = 1'b0;
        end else if (bus.r1_req) begin
            acc = 1'b1;
            sel = 1'b1;
        end
    end

    always_comb begin
        if (sel) begin
            s_wr    = bus.r1_wr;
            s_addr  = bus.r1_addr;
            s_wdata = bus.r1_wdata;
            s_wmask = bus.r1_wmask;
        end else begin
            s_wr    = bus.r0_wr;
            s_addr  = bus.r0_addr;
            s_wdata = bus.r0_wdata;
            s_wmask = bus.r0_wmask;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and SRAM pin drive
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        rvalid_d = 2'b00;

        bus.r0_gnt = 1'b0;
        bus.r1_gnt = 1'b0;
        bus.A      = '0;
        bus.CEN    = 1'b1;
        bus.GWEN   = 1'b1;
        bus.WEN    = '1;
        bus.D      = '0;

        case (state_q)
            ST_INIT: begin
                bus.A    = cnt_q;
                bus.CEN  = 1'b0;
                bus.GWEN = 1'b0;
                bus.WEN  = '0;
                bus.D    = INIT_VAL;
                // Counter wraps to 0 naturally after the last entry.
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                if (clr_req) begin
                    // Port stays idle this cycle; sweep starts next cycle.
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (acc) begin
                    bus.r0_gnt = ~sel;
                    bus.r1_gnt = sel;
                    rr_d       = sel;
                    bus.A      = s_addr;
                    bus.CEN    = 1'b0;
                    if (s_wr) begin
                        bus.GWEN = 1'b0;
                        bus.WEN  = ~s_wmask;
                        bus.D    = s_wdata;
                    end else begin
                        rvalid_d[sel] = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            rr_q     <= 1'b1;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign init_busy     = (state_q == ST_INIT);
    assign bus.r0_rvalid = rvalid_q[0];
    assign bus.r1_rvalid = rvalid_q[1];
    // Q is shared; each requester qualifies it with its own rvalid.
    assign bus.r0_rdata  = bus.Q;
    assign bus.r1_rdata  = bus.Q;

endmodule

// File: tb/tb_ct_f_spsram_512x7_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_f_spsram_512x7_ctrl
//
// Bench for the 512x7 SRAM controller. A behavioural SRAM answers the DUT's
// pins; a transaction-level model (memory array, sweep position, last winner,
// pending read) predicts every output each cycle; directed sequences add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ct_f_spsram_512x7_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 7;
    localparam int DEPTH = 512;

    logic clk;
    logic rst;
    logic clr_req;
    logic init_busy;

    ct_f_spsram_512x7_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ct_f_spsram_512x7_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .INIT_VAL  (7'h00)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .clr_req  (clr_req),
        .init_busy(init_busy),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural SRAM on the DUT pins ----------------
    logic [DW-1:0] sram [DEPTH];
    logic          seeded = 1'b0;

    always @(posedge clk) begin
        if (!seeded) begin
            // Non-zero power-up contents so the init sweep is observable.
            for (int i = 0; i < DEPTH; i++) sram[i] <= 7'(i * 37 + 5);
            seeded <= 1'b1;
        end else if (bus.CEN === 1'b0) begin
            if (bus.GWEN === 1'b0)
                sram[bus.A] <= (sram[bus.A] & bus.WEN) | (bus.D & ~bus.WEN);
            else
                bus.Q <= sram[bus.A];
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_init   = 1'b1;
    int            m_cnt    = 0;
    int            m_last   = 1;
    bit            m_rv0    = 1'b0;
    bit            m_rv1    = 1'b0;
    logic [DW-1:0] m_rdata  = '0;

    always @(negedge clk) begin
        int            who;
        logic          e_g0, e_g1, e_cen, e_gwen, w_wr;
        logic [AW-1:0] e_a, w_addr;
        logic [DW-1:0] e_wen, e_d, w_data, w_mask;
        bit            n_rv0, n_rv1;

        who = -1;
        e_g0 = 0; e_g1 = 0; e_cen = 1; e_gwen = 1; e_a = '0; e_wen = '1; e_d = '0;
        w_wr = 0; w_addr = '0; w_data = '0; w_mask = '0;

        if (m_init) begin
            e_a = AW'(m_cnt); e_cen = 0; e_gwen = 0; e_wen = '0; e_d = 7'h00;
        end else if (!clr_req) begin
            if (bus.r0_req && bus.r1_req) who = (m_last == 0) ? 1 : 0;
            else if (bus.r0_req)          who = 0;
            else if (bus.r1_req)          who = 1;
            if (who == 0) begin
                w_wr = bus.r0_wr; w_addr = bus.r0_addr; w_data = bus.r0_wdata; w_mask = bus.r0_wmask;
                e_g0 = 1;
            end else if (who == 1) begin
                w_wr = bus.r1_wr; w_addr = bus.r1_addr; w_data = bus.r1_wdata; w_mask = bus.r1_wmask;
                e_g1 = 1;
            end
            if (who >= 0) begin
                e_a = w_addr; e_cen = 0;
                if (w_wr) begin e_gwen = 0; e_wen = ~w_mask; e_d = w_data; end
            end
        end

        chk("m_busy",   init_busy,     m_init);
        chk("m_gnt0",   bus.r0_gnt,    e_g0);
        chk("m_gnt1",   bus.r1_gnt,    e_g1);
        chk("m_A",      bus.A,         e_a);
        chk("m_CEN",    bus.CEN,       e_cen);
        chk("m_GWEN",   bus.GWEN,      e_gwen);
        chk("m_WEN",    bus.WEN,       e_wen);
        if (e_cen || !e_gwen) chk("m_D", bus.D, e_d);
        chk("m_rv0",    bus.r0_rvalid, m_rv0);
        chk("m_rv1",    bus.r1_rvalid, m_rv1);
        if (m_rv0) chk("m_rdata0", bus.r0_rdata, m_rdata);
        if (m_rv1) chk("m_rdata1", bus.r1_rdata, m_rdata);

        // Advance the model to the state after the coming clock edge.
        n_rv0 = (who == 0) && !w_wr;
        n_rv1 = (who == 1) && !w_wr;
        if (n_rv0 || n_rv1) m_rdata = m_mem[w_addr];
        if (!e_cen && !e_gwen) m_mem[e_a] = (m_mem[e_a] & e_wen) | (e_d & ~e_wen);
        m_rv0 = n_rv0;
        m_rv1 = n_rv1;

        if (rst) begin
            m_init = 1; m_cnt = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0;
        end else if (m_init) begin
            m_cnt++;
            if (m_cnt == DEPTH) begin m_cnt = 0; m_init = 0; end
        end else if (clr_req) begin
            m_init = 1; m_cnt = 0;
        end else if (who >= 0) begin
            m_last = who;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.r0_req = 0; bus.r0_wr = 0; bus.r0_addr = '0; bus.r0_wdata = '0; bus.r0_wmask = '0;
        bus.r1_req = 0; bus.r1_wr = 0; bus.r1_addr = '0; bus.r1_wdata = '0; bus.r1_wmask = '0;
    endtask

    task automatic set_req(input int r, input bit wr, input int addr, input int data, input int mask);
        if (r == 0) begin
            bus.r0_req = 1; bus.r0_wr = wr; bus.r0_addr = AW'(addr);
            bus.r0_wdata = DW'(data); bus.r0_wmask = DW'(mask);
        end else begin
            bus.r1_req = 1; bus.r1_wr = wr; bus.r1_addr = AW'(addr);
            bus.r1_wdata = DW'(data); bus.r1_wmask = DW'(mask);
        end
    endtask

    task automatic do_write(input int r, input int addr, input int data, input int mask, input string nm);
        set_req(r, 1, addr, data, mask);
        @(negedge clk);
        chk({nm, "_gnt"}, (r == 0) ? bus.r0_gnt : bus.r1_gnt, 1);
        step();
        idle();
    endtask

    task automatic do_read(input int r, input int addr, input logic [DW-1:0] exp, input string nm);
        set_req(r, 0, addr, 0, 0);
        @(negedge clk);
        chk({nm, "_gnt"}, (r == 0) ? bus.r0_gnt : bus.r1_gnt, 1);
        step();
        idle();
        @(negedge clk);
        chk({nm, "_rvalid"}, (r == 0) ? bus.r0_rvalid : bus.r1_rvalid, 1);
        chk({nm, "_rdata"},  (r == 0) ? bus.r0_rdata  : bus.r1_rdata,  exp);
        step();
    endtask

    // Counts consecutive busy cycles starting at the current negedge.
    task automatic count_busy(output int n);
        n = 0;
        while (init_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        logic [AW-1:0] last_a;

        rst = 1; clr_req = 0;
        idle();
        step(); step(); step();
        @(negedge clk);
        chk("rst_busy",   init_busy,     1);
        chk("rst_gnt0",   bus.r0_gnt,    0);
        chk("rst_rvalid", bus.r0_rvalid, 0);
        chk("rst_CEN",    bus.CEN,       0);
        chk("rst_GWEN",   bus.GWEN,      0);

        // Init sweep: 512 busy cycles, A = 0 .. 511.
        step();
        rst = 0;
        @(negedge clk);
        chk("init_first_A", bus.A, 0);
        n = 0; last_a = '0;
        while (init_busy && n < 2000) begin
            last_a = bus.A;
            n++;
            @(negedge clk);
        end
        chk("init_len",    n,      512);
        chk("init_last_A", last_a, 511);
        step();

        do_read(0, 0,   7'h00, "init_rd0");
        do_read(1, 255, 7'h00, "init_rd255");
        do_read(0, 511, 7'h00, "init_rd511");

        // Masked write: 7F then 00 under mask 0F leaves 70.
        do_write(0, 5, 7'h7F, 7'h7F, "mw_a");
        do_write(0, 5, 7'h00, 7'h0F, "mw_b");
        do_read(0, 5, 7'h70, "mw_rd");

        // Zero mask consumes the slot but leaves the entry unchanged.
        do_write(1, 5, 7'h0A, 7'h00, "mw_zero");
        do_read(1, 5, 7'h70, "mw_zero_rd");

        // Write followed immediately by a read of the same address.
        set_req(0, 1, 7, 7'h3C, 7'h7F);
        @(negedge clk);
        chk("b2b_wgnt", bus.r0_gnt, 1);
        step();
        idle();
        set_req(1, 0, 7, 0, 0);
        @(negedge clk);
        chk("b2b_rgnt", bus.r1_gnt, 1);
        step();
        idle();
        @(negedge clk);
        chk("b2b_rvalid", bus.r1_rvalid, 1);
        chk("b2b_rdata",  bus.r1_rdata,  7'h3C);
        step();

        // Contention: last winner is r1, so grants go 0,1,0,1.
        do_write(0, 1, 7'h11, 7'h7F, "ct_w1");
        do_write(1, 2, 7'h22, 7'h7F, "ct_w2");
        set_req(0, 0, 1, 0, 0);
        set_req(1, 0, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ct_gnt0", bus.r0_gnt, (i % 2 == 0) ? 1 : 0);
            chk("ct_gnt1", bus.r1_gnt, (i % 2 == 1) ? 1 : 0);
            if (i > 0) begin
                if ((i - 1) % 2 == 0) begin
                    chk("ct_rv0", bus.r0_rvalid, 1);
                    chk("ct_rd0", bus.r0_rdata,  7'h11);
                end else begin
                    chk("ct_rv1", bus.r1_rvalid, 1);
                    chk("ct_rd1", bus.r1_rdata,  7'h22);
                end
            end
            step();
        end
        idle();
        @(negedge clk);
        chk("ct_rv1_last", bus.r1_rvalid, 1);
        chk("ct_rd1_last", bus.r1_rdata,  7'h22);
        step();

        // clr_req while r1 requests: no grant, full sweep, then r1 served.
        do_write(0, 10, 7'h55, 7'h7F, "clr_w");
        set_req(1, 0, 10, 0, 0);
        clr_req = 1;
        @(negedge clk);
        chk("clr_gnt1", bus.r1_gnt, 0);
        chk("clr_CEN",  bus.CEN,    1);
        step();
        clr_req = 0;
        @(negedge clk);
        count_busy(n);
        chk("clr_sweep_len", n, 512);
        chk("clr_late_gnt",  bus.r1_gnt, 1);
        step();
        idle();
        @(negedge clk);
        chk("clr_rvalid", bus.r1_rvalid, 1);
        chk("clr_rdata",  bus.r1_rdata,  7'h00);
        step();

        // Reset mid-sweep at address 300.
        do_write(0, 10, 7'h2B, 7'h7F, "rs_w");
        clr_req = 1;
        step();
        clr_req = 0;
        @(negedge clk);
        n = 0;
        while (bus.A != 299 && n < 600) begin
            n++;
            @(negedge clk);
        end
        chk("rs_reach_299", bus.A, 299);
        step();
        rst = 1;
        @(negedge clk);
        chk("rs_A_300", bus.A, 300);
        step();
        rst = 0;
        set_req(0, 0, 10, 0, 0);
        @(negedge clk);
        chk("rs_restart_A", bus.A, 0);
        chk("rs_no_gnt",    bus.r0_gnt, 0);
        count_busy(n);
        chk("rs_sweep_len", n, 512);
        chk("rs_first_gnt", bus.r0_gnt, 1);
        step();
        idle();
        @(negedge clk);
        chk("rs_rvalid", bus.r0_rvalid, 1);
        chk("rs_rdata",  bus.r0_rdata,  7'h00);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
